// File: rtl/uart_rx_deser_if.sv
// FIFO-side bundle of the UART receive deserializer: write port, full flag
// and the three error pulses. The deserializer drives it through the master
// modport, and the FIFO/error sink connects through the slave modport.
interface uart_rx_deser_if #(
  parameter int D_WIDTH = 8
);
  logic [D_WIDTH-1:0] wrt_data_o;
  logic               wrt_ena_o;
  logic               full_i;
  logic               frame_err_o;
  logic               overrun_err_o;
  logic               parity_err_o;

  modport master (
    output wrt_data_o,
    output wrt_ena_o,
    input  full_i,
    output frame_err_o,
    output overrun_err_o,
    output parity_err_o
  );

  modport slave (
    input  wrt_data_o,
    input  wrt_ena_o,
    output full_i,
    input  frame_err_o,
    input  overrun_err_o,
    input  parity_err_o
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserializer. It oversamples the async rx line and checks the
// start and stop bits. It assembles an LSB-first word and pushes it into the
// RX FIFO with a one-cycle write strobe. Framing, overrun and parity problems
// are reported as one-cycle pulses, and exactly one pulse is produced per
// frame.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit. Without the macro, parity_err_o is tied 0.
//
// state  | meaning
// IDLE   | line idle, counters held at 0, waiting for rx_s low
// START  | confirming the start bit at its centre; a high level here is a glitch
// DATA   | sampling D_WIDTH data bits at each bit centre, LSB first
// PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
// STOP   | sampling the stop bit and issuing the single per-frame result
// BREAK  | stop bit was 0; waiting for the line to return high
module uart_rx_deser #(
  parameter int D_WIDTH    = 8,
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             rx_i,
  uart_rx_deser_if.master  fifo
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(D_WIDTH + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t             state, state_nxt;
  logic               rx_meta, rx_s;
  logic [TW-1:0]      tick_cnt, tick_nxt;
  logic [SW-1:0]      samp_cnt, samp_nxt;
  logic [BW-1:0]      bit_cnt, bit_nxt;
  logic [D_WIDTH-1:0] shift_reg, shift_nxt;
  logic [D_WIDTH-1:0] data_q, data_nxt;
  logic               ena_q, ena_nxt;
  logic               ferr_q, ferr_nxt;
  logic               oerr_q, oerr_nxt;
  logic               perr_q, perr_nxt;
  logic               tick;
  logic               bit_end;
`ifdef UART_RX_PARITY_EN
  logic               par_bit, par_nxt;
`endif

  assign tick    = (tick_cnt == TICK_LAST);
  assign bit_end = tick && (samp_cnt == SAMP_LAST);

  // Two-flop synchronizer. It resets to the idle-high level so that reset
  // release cannot look like a start bit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered result outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      ena_q     <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      samp_cnt  <= samp_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      data_q    <= data_nxt;
      ena_q     <= ena_nxt;
      ferr_q    <= ferr_nxt;
      oerr_q    <= oerr_nxt;
      perr_q    <= perr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_nxt;
`endif
    end
  end

  // Next-state logic. Each frame yields one result pulse, decided at the
  // centre of the stop bit.
  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    data_nxt  = data_q;
    ena_nxt   = 1'b0;
    ferr_nxt  = 1'b0;
    oerr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
`endif

    if (state == IDLE || state == BREAK) begin
      tick_nxt = '0;
    end else if (tick) begin
      tick_nxt = '0;
    end else begin
      tick_nxt = tick_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        samp_nxt = '0;
        bit_nxt  = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (tick) begin
          if (samp_cnt == SAMP_HALF) begin
            samp_nxt  = '0;
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            samp_nxt = samp_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (bit_end) begin
          samp_nxt  = '0;
          shift_nxt = {rx_s, shift_reg[D_WIDTH-1:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else if (tick) begin
          samp_nxt = samp_cnt + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          samp_nxt  = '0;
          par_nxt   = rx_s;
          state_nxt = STOP;
        end else if (tick) begin
          samp_nxt = samp_cnt + 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          samp_nxt = '0;
          if (!rx_s) begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_reg, par_bit}) begin
            perr_nxt  = 1'b1;
            state_nxt = IDLE;
`endif
          end else if (fifo.full_i) begin
            oerr_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ena_nxt   = 1'b1;
            data_nxt  = shift_reg;
            state_nxt = IDLE;
          end
        end else if (tick) begin
          samp_nxt = samp_cnt + 1'b1;
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign fifo.wrt_data_o    = data_q;
  assign fifo.wrt_ena_o     = ena_q;
  assign fifo.frame_err_o   = ferr_q;
  assign fifo.overrun_err_o = oerr_q;
  assign fifo.parity_err_o  = perr_q;

endmodule
